// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store control stage: control bundle, fault codes,
// response payload and the request legality check.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        DB = 2'd0,
        DH = 2'd1,
        DW = 2'd2,
        DX = 2'd3
    } data_width;

    typedef struct packed {
        logic      l;
        logic      s;
        data_width dw;
        logic      sign;
    } control_signals_t;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_RANGE    = 2'd2,
        FLT_ILLEGAL  = 2'd3
    } lsu_fault_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        is_load;
        lsu_fault_e  fault;
    } lsu_rsp_t;

    // data_src always touches a 4-byte window, so the range limit ignores width.
    function automatic lsu_fault_e lsu_check(input logic [31:0] addr,
                                             input control_signals_t cs,
                                             input int mem_bytes = 256);
        logic [32:0] limit;
        limit = 33'(mem_bytes - 4);
        if ((cs.l && cs.s) || (!cs.l && !cs.s) || (cs.dw == DX))
            return FLT_ILLEGAL;
        if ((cs.dw == DH && addr[0]) || (cs.dw == DW && addr[1:0] != 2'b00))
            return FLT_MISALIGN;
        if ({1'b0, addr} > limit)
            return FLT_RANGE;
        return FLT_NONE;
    endfunction

endpackage

// File: rtl/lsu_rsp_fifo.sv
// In-order response queue; head reads as zero while empty so idle outputs stay clean.
module lsu_rsp_fifo
    import lsu_ctrl_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  lsu_rsp_t                     push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output lsu_rsp_t                     head
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    lsu_rsp_t      store [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != CW'(DEPTH));

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    assign head = (count != '0) ? store[rd_ptr] : '0;

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: checks requests, drives data_src, and returns
// one in-order response per request through a small response queue.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int RSP_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  control_signals_t req_cs,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_is_load,
    output lsu_fault_e       rsp_fault,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output control_signals_t mem_cs,
    input  logic [31:0]      mem_rdata
);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic             accept;
    lsu_fault_e       req_fault;
    logic             pend_v;
    logic             pend_is_load;
    lsu_fault_e       pend_fault;
    logic [CW-1:0]    fifo_count;
    lsu_rsp_t         push_data;
    lsu_rsp_t         head;

    assign req_fault = lsu_check(req_addr, req_cs, MEM_BYTES);

    // A request in flight in the pend stage already owns a queue slot.
    assign req_ready = rst_n && ((int'(fifo_count) + int'(pend_v)) < RSP_DEPTH);
    assign accept    = req_valid && req_ready;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_cs    = '0;
        if (accept) begin
            mem_addr  = req_addr;
            mem_wdata = req_wdata;
            mem_cs    = req_cs;
            if (req_fault != FLT_NONE) begin
                mem_cs.l = 1'b0;
                mem_cs.s = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v       <= 1'b0;
            pend_is_load <= 1'b0;
            pend_fault   <= FLT_NONE;
        end else begin
            pend_v       <= accept;
            pend_is_load <= req_cs.l;
            pend_fault   <= req_fault;
        end
    end

    // mem_rdata is valid here only for a fault-free load accepted last cycle.
    always_comb begin
        push_data.rdata   = (pend_is_load && pend_fault == FLT_NONE) ? mem_rdata : '0;
        push_data.is_load = pend_is_load;
        push_data.fault   = pend_fault;
    end

    lsu_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pend_v),
        .push_data (push_data),
        .pop       (rsp_ready),
        .count     (fifo_count),
        .head      (head)
    );

    assign rsp_valid   = (fifo_count != '0);
    assign rsp_rdata   = head.rdata;
    assign rsp_is_load = head.is_load;
    assign rsp_fault   = head.fault;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: data_src model, a queue-based response model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    localparam int MEM_BYTES = 256;
    localparam int RSP_DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_addr = '0;
    logic [31:0]      req_wdata = '0;
    control_signals_t req_cs = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_rdata;
    logic             rsp_is_load;
    lsu_fault_e       rsp_fault;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    control_signals_t mem_cs;
    logic [31:0]      mem_rdata = '0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_acc = 0;
    int l_seen = 0;

    lsu_ctrl #(.MEM_BYTES(MEM_BYTES), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_cs(req_cs),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_is_load(rsp_is_load), .rsp_fault(rsp_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_cs(mem_cs),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        is_load;
        lsu_fault_e  fault;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        is_load;
        lsu_fault_e  fault;
        int          acc;
        int          pop;
    } log_t;

    exp_t       exp_q[$];
    log_t       log_q[$];
    logic [7:0] src_mem [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    function automatic int nbytes(input data_width dw);
        return (dw == DB) ? 1 : (dw == DH) ? 2 : 4;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input control_signals_t cs);
        int v;
        case (cs.dw)
            DB:      v = cs.sign ? int'($signed(raw[7:0]))  : int'(raw[7:0]);
            DH:      v = cs.sign ? int'($signed(raw[15:0])) : int'(raw[15:0]);
            default: v = int'(raw);
        endcase
        return 32'(v);
    endfunction

    function automatic lsu_fault_e model_fault(input logic [31:0] a, input control_signals_t cs);
        longint unsigned ua;
        int w;
        ua = 64'(a);
        if (cs.l == cs.s || cs.dw == DX) return FLT_ILLEGAL;
        w = nbytes(cs.dw);
        if ((ua % longint'(w)) != 0) return FLT_MISALIGN;
        if (ua + 4 > longint'(MEM_BYTES)) return FLT_RANGE;
        return FLT_NONE;
    endfunction

    function automatic control_signals_t mk(input logic l, input logic s, input data_width dw, input logic sign);
        control_signals_t c;
        c.l = l; c.s = s; c.dw = dw; c.sign = sign;
        return c;
    endfunction

    // data_src: stores commit on negedge, loads are registered on posedge
    initial begin
        for (int i = 0; i < MEM_BYTES; i++) src_mem[i] = pat(i);
        forever begin
            @(negedge clk);
            if (mem_cs.s)
                for (int b = 0; b < nbytes(mem_cs.dw); b++)
                    src_mem[(int'(mem_addr) + b) % MEM_BYTES] = mem_wdata[8*b +: 8];
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (mem_cs.l) begin
                int a;
                a = int'(mem_addr) % MEM_BYTES;
                mem_rdata <= extend({src_mem[(a+3)%MEM_BYTES], src_mem[(a+2)%MEM_BYTES],
                                     src_mem[(a+1)%MEM_BYTES], src_mem[a]}, mem_cs);
            end
        end
    end

    // Reference model and per-cycle compare, sampled mid-cycle
    initial begin
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = pat(i);
        forever begin
            logic exp_ready, exp_valid;
            @(negedge clk);
            if (mem_cs.l) l_seen++;
            if (!rst_n) begin
                exp_q.delete();
                chk("rst_req_ready", 32'(req_ready), 0);
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_mem_ls", {30'b0, mem_cs.l, mem_cs.s}, 0);
                continue;
            end
            exp_ready = (exp_q.size() < RSP_DEPTH);
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            exp_valid = (exp_q.size() > 0) && (exp_q[0].acc + 2 <= cyc);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                chk("rsp_is_load", 32'(rsp_is_load), 32'(exp_q[0].is_load));
                chk("rsp_fault", 32'(rsp_fault), 32'(exp_q[0].fault));
                if (rsp_ready) begin
                    log_t lg;
                    lg.rdata = rsp_rdata; lg.is_load = rsp_is_load; lg.fault = rsp_fault;
                    lg.acc = exp_q[0].acc; lg.pop = cyc;
                    log_q.push_back(lg);
                    void'(exp_q.pop_front());
                end
            end
            if (req_valid && exp_ready) begin
                exp_t e;
                lsu_fault_e f;
                int a;
                f = model_fault(req_addr, req_cs);
                a = int'(req_addr[7:0]);
                e.fault = f; e.is_load = req_cs.l; e.acc = cyc; e.rdata = '0;
                if (f == FLT_NONE && req_cs.l)
                    e.rdata = extend({ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]}, req_cs);
                if (f == FLT_NONE && req_cs.s)
                    for (int b = 0; b < nbytes(req_cs.dw); b++) ref_mem[a+b] = req_wdata[8*b +: 8];
                exp_q.push_back(e);
                n_acc++;
                chk("mem_addr", mem_addr, req_addr);
                chk("mem_wdata", mem_wdata, req_wdata);
                chk("mem_l", 32'(mem_cs.l), 32'(req_cs.l && f == FLT_NONE));
                chk("mem_s", 32'(mem_cs.s), 32'(req_cs.s && f == FLT_NONE));
                chk("mem_dw", 32'(mem_cs.dw), 32'(req_cs.dw));
            end else begin
                chk("idle_mem_addr", mem_addr, 0);
                chk("idle_mem_wdata", mem_wdata, 0);
                chk("idle_mem_ls", {30'b0, mem_cs.l, mem_cs.s}, 0);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input control_signals_t cs);
        int n;
        logic acc;
        n = 0; acc = 1'b0;
        req_addr = a; req_wdata = d; req_cs = cs; req_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = req_ready;
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_cs = '0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL issue_timeout: got no accept, expected accept within 100 cycles (addr 0x%08h)", a);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, l0, a0;
        logic done;
        done = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_fault", 32'(rsp_fault), 0);
        chk("reset_rsp_is_load", 32'(rsp_is_load), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // Store word then load it back
        base = log_q.size();
        issue(32'h10, 32'hDEADBEEF, mk(0, 1, DW, 0));
        issue(32'h10, 32'h0, mk(1, 0, DW, 1));
        drain();
        chk("t1_store_rdata", log_q[base].rdata, 0);
        chk("t1_store_fault", 32'(log_q[base].fault), 0);
        chk("t1_store_is_load", 32'(log_q[base].is_load), 0);
        chk("t1_load_rdata", log_q[base+1].rdata, 32'hDEADBEEF);
        chk("t1_load_is_load", 32'(log_q[base+1].is_load), 1);
        chk("t1_load_latency", 32'(log_q[base+1].pop - log_q[base+1].acc), 2);

        // Byte store, signed and unsigned byte loads
        base = log_q.size();
        issue(32'h20, 32'h00000080, mk(0, 1, DB, 0));
        issue(32'h20, 32'h0, mk(1, 0, DB, 1));
        issue(32'h20, 32'h0, mk(1, 0, DB, 0));
        drain();
        chk("t2_lb", log_q[base+1].rdata, 32'hFFFFFF80);
        chk("t2_lbu", log_q[base+2].rdata, 32'h00000080);

        // Faults and their priority
        base = log_q.size();
        l0 = l_seen;
        issue(32'h21, 32'h0, mk(1, 0, DH, 0));
        issue(32'hFD, 32'h0, mk(1, 0, DB, 0));
        issue(32'h100, 32'h0, mk(1, 0, DW, 0));
        issue(32'hFD, 32'h0, mk(1, 0, DW, 0));
        issue(32'h10, 32'h0, mk(1, 1, DW, 0));
        issue(32'h10, 32'h0, mk(0, 1, DX, 0));
        issue(32'hFFFFFFFC, 32'h0, mk(0, 1, DW, 0));
        drain();
        chk("t3_no_mem_l", 32'(l_seen - l0), 0);
        chk("t3_lh_misalign", 32'(log_q[base].fault), 1);
        chk("t3_lb_range", 32'(log_q[base+1].fault), 2);
        chk("t3_lw_range", 32'(log_q[base+2].fault), 2);
        chk("t3_misalign_over_range", 32'(log_q[base+3].fault), 1);
        chk("t3_ls_illegal", 32'(log_q[base+4].fault), 3);
        chk("t3_dw_illegal", 32'(log_q[base+5].fault), 3);
        chk("t3_wrap_range", 32'(log_q[base+6].fault), 2);
        chk("t3_fault_rdata", log_q[base+1].rdata, 0);
        base = log_q.size();
        issue(32'hFC, 32'h0, mk(1, 0, DW, 0));
        drain();
        chk("t3_top_word_ok", 32'(log_q[base].fault), 0);

        // Burst of 8 loads at full rate
        for (int i = 0; i < 8; i++) issue(32'h40 + 32'(4*i), 32'h10000000 + 32'(i), mk(0, 1, DW, 0));
        drain();
        base = log_q.size();
        for (int i = 0; i < 8; i++) issue(32'h40 + 32'(4*i), 32'h0, mk(1, 0, DW, 0));
        drain();
        for (int i = 0; i < 8; i++) begin
            chk("t4_rdata", log_q[base+i].rdata, 32'h10000000 + 32'(i));
            chk("t4_latency", 32'(log_q[base+i].pop - log_q[base+i].acc), 2);
            if (i > 0) chk("t4_back_to_back", 32'(log_q[base+i].acc - log_q[base+i-1].acc), 1);
        end

        // Writeback stall fills exactly RSP_DEPTH slots
        base = log_q.size();
        rsp_ready = 1'b0;
        a0 = n_acc;
        fork
            begin
                for (int i = 0; i < 5; i++) issue(32'h40 + 32'(4*i), 32'h0, mk(1, 0, DW, 0));
            end
            begin
                repeat (8) @(negedge clk);
                chk("t5_accepts_when_stalled", 32'(n_acc - a0), RSP_DEPTH);
                chk("t5_ready_low", 32'(req_ready), 0);
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
        join
        drain();
        chk("t5_count", 32'(log_q.size() - base), 5);
        for (int i = 0; i < 5; i++) chk("t5_order", log_q[base+i].rdata, 32'h10000000 + 32'(i));

        // Reset right after a load accept
        base = log_q.size();
        issue(32'h44, 32'h0, mk(1, 0, DW, 0));
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rsp_valid_in_reset", 32'(rsp_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_no_stale_rsp", 32'(rsp_valid), 0);
            chk("t6_ready_after_reset", 32'(req_ready), 1);
        end
        chk("t6_no_log", 32'(log_q.size() - base), 0);
        @(posedge clk); #1;

        // Randomized traffic with random writeback stalls
        fork
            begin
                for (int k = 0; k < 400; k++) begin
                    logic [31:0] a;
                    int r, kind;
                    data_width dw;
                    logic l, s;
                    r = int'($urandom % 10);
                    if (r < 6)      a = $urandom % 256;
                    else if (r < 8) a = 32'(248 + ($urandom % 8));
                    else if (r == 8) a = $urandom;
                    else             a = 32'hFFFFFFFC | ($urandom % 4);
                    dw = ($urandom % 8 == 0) ? DX : data_width'($urandom % 3);
                    kind = int'($urandom % 10);
                    l = (kind < 4) || (kind == 8);
                    s = ((kind >= 4) && (kind < 8)) || (kind == 8);
                    if ($urandom % 4 != 0) a = a & ~32'(nbytes(dw) - 1);
                    issue(a, $urandom, mk(l, s, dw, 1'($urandom)));
                    repeat ($urandom % 3) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom % 4) != 0;
                end
            end
        join
        rsp_ready = 1'b1;
        drain();
        chk("final_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
